alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Initiator side of the ALU operand/mode interface: accepts 16-bit instructions over a valid/ready handshake and holds a 4-entry register file.
- Drives ALU operands and mode, captures ALU result and flags, then writes back.
- Sits between the instruction fetch stage and the combinational ALU of the 8-bit microprocessor.

Parameters:
- DATA_W, 8, operand/result/register width.
- NREGS, 4, register file depth; fixed by the 2-bit register fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  16  [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- alu_in1  out  DATA_W  registered operand A.
- alu_in2  out  DATA_W  registered operand B.
- alu_mode  out  4  registered ALU mode.
- alu_out  in  DATA_W  ALU result (combinational from alu_in*/alu_mode).
- alu_zero  in  1  ALU zero flag.
- alu_carry  in  1  ALU carry/borrow/less-than flag.
- flag_zero  out  1  architectural zero flag.
- flag_carry  out  1  architectural carry flag.
- done  out  1  one-cycle pulse: instruction retired.
- err  out  1  one-cycle pulse with done: illegal opcode.
- dbg_addr  in  2  register file debug read address.
- dbg_data  out  DATA_W  combinational read of rf[dbg_addr].

Behaviour:
- Reset (async, any state): state=IDLE; rf[0..3]=0; flag_zero=0, flag_carry=0; alu_in1=0, alu_in2=0, alu_mode=0; done=0, err=0.
- FSM states and transitions: IDLE -> EXEC -> WB -> IDLE. instr_ready=1 only in IDLE.
- IDLE: on instr_valid&&instr_ready, latch opcode/rd/imm, read rf[rd] and rf[rs], load alu_in1/alu_in2/alu_mode, go to EXEC. With instr_valid=0, stay in IDLE.
- EXEC: hold ALU inputs stable for one full cycle (ALU settles), go to WB.
- WB: sample alu_out/alu_zero/alu_carry at the WB clock edge; write rd and flags per opcode; go to IDLE with done=1 (and err if illegal) in that IDLE cycle.
- Fixed latency: handshake in cycle N; done and updated rf/flags visible in cycle N+3. Next handshake is accepted in N+3, so throughput is 1 instruction per 3 cycles.
- Operands are read at acceptance; the prior write is already committed, so no forwarding is needed.
- ALU mode encoding (package constants): ADD=0, SUB=1, CMP=2, AND=3, OR=4, XOR=5.

Opcodes:
- 0 ADD: in1=rf[rd], in2=rf[rs], mode ADD; rd<=alu_out; Z<=alu_zero; C<=alu_carry.
- 1 SUB: as ADD with mode SUB; C=borrow from ALU.
- 2 CMP: mode CMP; no rd write; Z<=alu_zero (equal); C<=alu_carry (in1<in2).
- 3 AND / 4 OR / 5 XOR: rd<=alu_out; Z<=alu_zero; C<=0.
- 6 LDI: rd<=imm; ALU unused (mode ADD, in2=0); flags unchanged.
- 7 ADDI: in2=imm, mode ADD; writeback as ADD.
- 8 MOV: rd<=rf[rs]; flags unchanged.
- 15 NOP: no writes; done only.
- 9..14 illegal: no rf/flag writes; done=1 and err=1.
- Arithmetic is modulo 2^DATA_W; carry comes only from the ALU.
- rd==rs is legal: both operands equal the old value.
- instr is ignored outside IDLE; instr_valid held high during busy cycles is not consumed.

Decomposition:
- Shared package alu_pkg: ALU mode constants, opcode constants, instruction field positions, FSM state encoding. The ALU reuses the mode constants.
- One sub-module, alu_seq_regfile: 4x DATA_W registers, async clear, single write port, two read ports plus the debug read port.

Test Plan:
- LDI r0,0x7F; LDI r1,0x01; ADD r0,r1 -> done 3 cycles after each handshake; r0=0x80, Z=0, C=0.
- LDI r2,0xFF; LDI r3,0x01; ADD r2,r3 -> r2=0x00, Z=1, C=1; then AND r2,r3 -> r2=0x00, Z=1, C=0.
- r0=0x05, r1=0x09: CMP r0,r1 -> r0 unchanged, Z=0, C=1. CMP r1,r1 -> Z=1, C=0.
- SUB r0,r1 with 0x05-0x09 -> r0=0xFC, C=1; MOV r3,r0 -> r3=0xFC, flags unchanged.
- opcode 0xA with instr_valid held high for 6 cycles -> exactly 2 acceptances (cycles 0 and 3); each gives done=err=1 with no rf/flag change.
- Assert rst during EXEC of ADD -> immediately IDLE, instr_ready=1, all rf=0, flags=0, no done pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the 8-bit ALU sequencer: ALU modes, opcodes,
// instruction field layout and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_CMP = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_CMP  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LDI  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_MOV  = 4'd8;
  localparam logic [3:0] OP_NOP  = 4'd15;

  // Field layout of the 16-bit instruction word, MSB first.
  typedef struct packed {
    logic [3:0] opc;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
  } instr_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  function automatic logic op_legal(input logic [3:0] opc);
    return (opc <= OP_MOV) || (opc == OP_NOP);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU sequencer: async clear, one write port,
// two operand read ports and a debug read port.
module alu_seq_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [NREGS-1:0][DATA_W-1:0] rf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_q <= '0;
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = rf_q[raddr_a_i];
  assign rdata_b_o  = rf_q[raddr_b_i];
  assign dbg_data_o = rf_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer driving an external combinational ALU:
// accept in IDLE, let the ALU settle in EXEC, write back in WB.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_mode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              done,
  output logic              err,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  instr_t ins;
  assign ins = instr;

  logic [1:0]        state_q, state_d;
  logic [3:0]        opc_q;
  logic [1:0]        rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] in1_q, in2_q, in2_d;
  logic [3:0]        mode_q, mode_d;
  logic              zf_q, zf_d, cf_q, cf_d;
  logic              done_q, err_q;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              accept;

  assign accept = (state_q == ST_IDLE) && instr_valid;

  alu_seq_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk_i      (clk),
    .rst_i      (rst),
    .we_i       (we),
    .waddr_i    (rd_q),
    .wdata_i    (wdata),
    .raddr_a_i  (ins.rd),
    .rdata_a_o  (rdata_a),
    .raddr_b_i  (ins.rs),
    .rdata_b_o  (rdata_b),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (instr_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand B is the source register unless the opcode substitutes an immediate.
  always_comb begin
    mode_d = ALU_ADD;
    in2_d  = rdata_b;
    case (ins.opc)
      OP_SUB:  mode_d = ALU_SUB;
      OP_CMP:  mode_d = ALU_CMP;
      OP_AND:  mode_d = ALU_AND;
      OP_OR:   mode_d = ALU_OR;
      OP_XOR:  mode_d = ALU_XOR;
      OP_LDI:  in2_d  = '0;
      OP_ADDI: in2_d  = DATA_W'(ins.imm);
      default: ;
    endcase
  end

  // MOV reuses the latched operand B as its write data.
  always_comb begin
    we    = 1'b0;
    wdata = alu_out;
    zf_d  = zf_q;
    cf_d  = cf_q;
    if (state_q == ST_WB) begin
      case (opc_q)
        OP_ADD, OP_SUB, OP_ADDI: begin
          we   = 1'b1;
          zf_d = alu_zero;
          cf_d = alu_carry;
        end
        OP_CMP: begin
          zf_d = alu_zero;
          cf_d = alu_carry;
        end
        OP_AND, OP_OR, OP_XOR: begin
          we   = 1'b1;
          zf_d = alu_zero;
          cf_d = 1'b0;
        end
        OP_LDI: begin
          we    = 1'b1;
          wdata = imm_q;
        end
        OP_MOV: begin
          we    = 1'b1;
          wdata = in2_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opc_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      mode_q  <= '0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      done_q  <= (state_q == ST_WB);
      err_q   <= (state_q == ST_WB) && !op_legal(opc_q);
      if (accept) begin
        opc_q  <= ins.opc;
        rd_q   <= ins.rd;
        imm_q  <= DATA_W'(ins.imm);
        in1_q  <= rdata_a;
        in2_q  <= in2_d;
        mode_q <= mode_d;
      end
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;
  assign alu_mode    = mode_q;
  assign flag_zero   = zf_q;
  assign flag_carry  = cf_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU environment, a retirement-level
// reference model, a per-cycle compare process and directed literal pins.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_mode;
  logic        alu_zero, alu_carry;
  logic        flag_zero, flag_carry, done, err;
  logic [1:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;

  int n_tot  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_mode(alu_mode), .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .done(done), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Combinational ALU seen by the sequencer.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum   = {1'b0, alu_in1} + {1'b0, alu_in2};
    alu_out   = 8'h00;
    alu_carry = 1'b0;
    case (alu_mode)
      4'd0: begin alu_out = alu_sum[7:0]; alu_carry = alu_sum[8]; end
      4'd1, 4'd2: begin alu_out = alu_in1 - alu_in2; alu_carry = alu_in1 < alu_in2; end
      4'd3: alu_out = alu_in1 & alu_in2;
      4'd4: alu_out = alu_in1 | alu_in2;
      4'd5: alu_out = alu_in1 ^ alu_in2;
      default: ;
    endcase
    alu_zero = (alu_out == 8'h00);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: an instruction takes effect three cycles after acceptance.
  logic [7:0] m_rf [4] = '{default: 8'h00};
  logic       m_z = 1'b0, m_c = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int         m_cnt = 0;
  logic       p_we, p_wf, p_ill, p_z, p_c, x_ops, x_in1;
  logic [1:0] p_rd;
  logic [7:0] p_val, x_in1v, x_in2v, ma, mb, mi;
  logic [3:0] x_mode, mop;
  logic [8:0] ms;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      foreach (m_rf[i]) m_rf[i] = 8'h00;
      m_z = 0; m_c = 0; m_done = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_done = 0; m_err = 0;
      if (m_cnt == 1) begin
        if (p_we) m_rf[p_rd] = p_val;
        if (p_wf) begin m_z = p_z; m_c = p_c; end
        m_done = 1; m_err = p_ill;
      end
      if (m_cnt > 0) m_cnt--;
      else if (instr_valid) begin
        mop = instr[15:12]; p_rd = instr[11:10];
        ma = m_rf[instr[11:10]]; mb = m_rf[instr[9:8]]; mi = instr[7:0];
        p_we = 0; p_wf = 0; p_ill = 0; p_val = 0; p_z = 0; p_c = 0;
        x_ops = 1; x_in1 = 1; x_in1v = ma; x_in2v = mb; x_mode = 4'd0;
        case (mop)
          4'd0: begin ms = ma + mb; p_val = ms[7:0]; p_c = ms[8]; p_we = 1; p_wf = 1; end
          4'd1: begin p_val = ma - mb; p_c = ma < mb; p_we = 1; p_wf = 1; x_mode = 4'd1; end
          4'd2: begin p_val = ma - mb; p_c = ma < mb; p_wf = 1; x_mode = 4'd2; end
          4'd3: begin p_val = ma & mb; p_we = 1; p_wf = 1; x_mode = 4'd3; end
          4'd4: begin p_val = ma | mb; p_we = 1; p_wf = 1; x_mode = 4'd4; end
          4'd5: begin p_val = ma ^ mb; p_we = 1; p_wf = 1; x_mode = 4'd5; end
          4'd6: begin p_val = mi; p_we = 1; x_in1 = 0; x_in2v = 8'h00; end
          4'd7: begin ms = ma + mi; p_val = ms[7:0]; p_c = ms[8]; p_we = 1; p_wf = 1; x_in2v = mi; end
          4'd8: begin p_val = mb; p_we = 1; x_ops = 0; end
          4'd15: x_ops = 0;
          default: begin p_ill = 1; x_ops = 0; end
        endcase
        p_z = (p_val == 8'h00);
        m_cnt = 2;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("ready", instr_ready, m_cnt == 0);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("flag_zero", flag_zero, m_z);
    chk("flag_carry", flag_carry, m_c);
    chk("dbg_data", dbg_data, m_rf[dbg_addr]);
    if (m_cnt != 0 && x_ops) begin
      chk("alu_mode", alu_mode, x_mode);
      chk("alu_in2", alu_in2, x_in2v);
      if (x_in1) chk("alu_in1", alu_in1, x_in1v);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [7:0] imm);
    instr = {op, rd, rs, imm};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pin(input logic [1:0] a, input logic [7:0] lit, input string nm);
    dbg_addr = a;
    #1;
    chk(nm, dbg_data, lit);
    chk({nm, "_model"}, m_rf[a], lit);
  endtask

  task automatic pin_flags(input logic z, input logic c, input string nm);
    chk({nm, "_Z"}, flag_zero, z);
    chk({nm, "_C"}, flag_carry, c);
    chk({nm, "_Zmodel"}, m_z, z);
    chk({nm, "_Cmodel"}, m_c, c);
  endtask

  int n_ill;

  initial begin
    #2;
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_in1", alu_in1, 0);
    chk("rst_in2", alu_in2, 0);
    chk("rst_mode", alu_mode, 0);
    pin_flags(0, 0, "rst");
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      chk("rst_rf", dbg_data, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    issue(4'd6, 2'd0, 2'd0, 8'h7F);
    issue(4'd6, 2'd1, 2'd0, 8'h01);
    issue(4'd0, 2'd0, 2'd1, 8'h00);
    chk("add_done_latency", done, 1);
    pin(2'd0, 8'h80, "add_r0");
    pin_flags(0, 0, "add1");

    issue(4'd6, 2'd2, 2'd0, 8'hFF);
    issue(4'd6, 2'd3, 2'd0, 8'h01);
    issue(4'd0, 2'd2, 2'd3, 8'h00);
    pin(2'd2, 8'h00, "add_wrap_r2");
    pin_flags(1, 1, "add_wrap");
    issue(4'd3, 2'd2, 2'd3, 8'h00);
    pin(2'd2, 8'h00, "and_r2");
    pin_flags(1, 0, "and");

    issue(4'd6, 2'd0, 2'd0, 8'h05);
    issue(4'd6, 2'd1, 2'd0, 8'h09);
    issue(4'd2, 2'd0, 2'd1, 8'h00);
    pin(2'd0, 8'h05, "cmp_r0");
    pin_flags(0, 1, "cmp_lt");
    issue(4'd2, 2'd1, 2'd1, 8'h00);
    pin_flags(1, 0, "cmp_eq");

    issue(4'd1, 2'd0, 2'd1, 8'h00);
    pin(2'd0, 8'hFC, "sub_r0");
    pin_flags(0, 1, "sub");
    issue(4'd8, 2'd3, 2'd0, 8'h00);
    pin(2'd3, 8'hFC, "mov_r3");
    pin_flags(0, 1, "mov");

    issue(4'd5, 2'd3, 2'd3, 8'h00);
    pin(2'd3, 8'h00, "xor_self");
    issue(4'd7, 2'd3, 2'd0, 8'h10);
    pin(2'd3, 8'h10, "addi_r3");
    issue(4'd4, 2'd3, 2'd1, 8'h00);
    pin(2'd3, 8'h19, "or_r3");
    issue(4'd15, 2'd3, 2'd1, 8'h00);
    chk("nop_done", done, 1);
    pin(2'd3, 8'h19, "nop_r3");

    // Illegal opcode with valid held high: only every third cycle is accepted.
    n_ill = 0;
    instr = {4'hA, 2'd1, 2'd0, 8'h55};
    instr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (err && done) n_ill++;
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (err) n_ill++;
    end
    chk("illegal_count", n_ill, 2);
    pin(2'd1, 8'h09, "illegal_r1");
    pin_flags(0, 0, "illegal");

    // Reset while an ADD sits in EXEC.
    instr = {4'd0, 2'd0, 2'd1, 8'h00};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_done", done, 0);
    pin_flags(0, 0, "midrst");
    for (int i = 0; i < 4; i++) pin(2'(i), 8'h00, "midrst_rf");
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    issue(4'd6, 2'd1, 2'd0, 8'h42);
    pin(2'd1, 8'h42, "post_rst_ldi");
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
